ps2_key_tracker: RTL and testbench
==================================

// Module: ps2_key_tracker
// PURPOSE
//  Sequences the PS/2 keyboard receiver's scan_ready/read handshake and decodes the byte stream.
//  Replaces the one-shot pulser plus ad-hoc history logic.
//  Strips E0 (extended) and F0 (break) prefixes, emits one event per key make/break,
//  and keeps a held-state vector of game keys for the input/control logic.
// PARAMETERS
//  PREFIX_TIMEOUT  2_500_000  clock50 cycles (50 ms) allowed between a prefix and its code byte
// PORTS
//  clock50      in   1  system clock, 50 MHz; all logic on posedge
//  reset        in   1  asynchronous, active-high; clears all state
//  scan_ready   in   1  receiver byte-available level, synchronous to clock50
//  scan_code    in   8  receiver byte, valid while scan_ready=1
//  read         out  1  one-cycle acknowledge pulse to the receiver
//  event_valid  out  1  one-cycle strobe: a complete key event is presented
//  event_code   out  8  final (non-prefix) scan code of the event
//  event_ext    out  1  event was E0-prefixed
//  event_break  out  1  1 = release (F0 seen), 0 = press
//  key_state    out  8  held keys: [0]up E0-75 [1]down E0-72 [2]left E0-6B [3]right E0-74
//                       [4]fire 14 [5]use 29 [6]strafe 11 [7]run 12 (ext flag must match exactly)
//  prefix_err   out  1  one-cycle strobe: prefix timed out and was discarded
// BEHAVIOUR
//  Reset: read=0, event_valid=0, event_code=0, event_ext=0, event_break=0, key_state=0,
//   prefix_err=0; FSM=IDLE; timeout counter=0; handshake armed.
//  Handshake: when armed and scan_ready=1 at edge T, capture scan_code and drive read=1 during
//   T..T+1 (exactly one cycle); disarm. Re-arm only after scan_ready is sampled 0.
//   A scan_ready held high is never consumed twice.
//  Decode (on the captured byte, cycle T+1); FSM states IDLE, EXT, BRK, EXT_BRK:
//   IDLE   : E0->EXT; F0->BRK; 00/AA/E1/EE/FA/FE/FF ignored (stay); else make event, ext=0.
//   EXT    : F0->EXT_BRK; E0 stays EXT; else make event, ext=1; ->IDLE.
//   BRK    : E0/F0 -> IDLE, no event (malformed); else break event, ext=0; ->IDLE.
//   EXT_BRK: E0/F0 -> IDLE, no event; else break event, ext=1; ->IDLE.
//  Event output: event_valid=1 at T+2 for one cycle; event_code/ext/break are registered
//   and hold until the next event. key_state bit updates in the same cycle as event_valid:
//   set on make, clear on break; non-mapped codes leave key_state unchanged.
//  Timeout: counter runs only in EXT/BRK/EXT_BRK and clears on every captured byte.
//   On reaching PREFIX_TIMEOUT-1: FSM->IDLE, prefix_err=1 for one cycle, no event.
//   If a byte is captured in the same cycle, the byte wins: no error, decode proceeds.
//  Counter width $clog2(PREFIX_TIMEOUT)+1; saturating, never wraps.
//  Reset mid-sequence (pending prefix or held keys) discards everything; no release events.
// CONFIGURATION
//  TYPEMATIC_FILTER_EN defined: a make for a mapped key whose key_state bit is already 1
//   (auto-repeat) produces no event_valid. Unmapped keys and all breaks are unaffected.
//  Undefined: every make byte, including typematic repeats, produces event_valid.
// STRUCTURE
//  Package ps2_kbd_pkg:
//   - prefix/special byte constants (E0, F0, E1, AA, FA, EE, FE, FF)
//   - FSM state enum
//   - the 8 key-map {ext, code} constants and their key_state bit indices
//  Sub-module ps2_keymap: combinational {ext, code} -> {hit, idx[2:0]} lookup.
//  The FSM, handshake and counter stay in this module.
// TESTING
//  1 scan_ready held high 20 cycles, byte 1D -> read high exactly 1 cycle;
//    exactly one event_valid with code 1D, ext=0, break=0.
//  2 Bytes E0,75 then E0,F0,75 -> make ext=1 then break ext=1;
//    key_state[0] goes 1 then 0; event_code=75 both times.
//  3 Bytes 14 then E0,14 (right ctrl) -> key_state[4]=1 after the first event only;
//    the second event has ext=1 and key_state is unchanged.
//  4 Byte F0, then idle PREFIX_TIMEOUT cycles (bench overrides to 100) -> prefix_err pulse;
//    a following 29 is a make and sets key_state[5].
//  5 Bytes 29,29,29 with TYPEMATIC_FILTER_EN -> 1 event; without the macro -> 3 events;
//    key_state[5]=1 in both builds.
//  6 Bytes E0,72 then reset asserted for 2 cycles -> all outputs 0 and FSM=IDLE;
//    next byte 72 gives ext=0.

Source files
------------

// File: rtl/ps2_kbd_pkg.sv
// Shared constants, FSM state type and game-key map for the PS/2 key tracker.
package ps2_kbd_pkg;

  localparam logic [7:0] B_00 = 8'h00;
  localparam logic [7:0] B_E0 = 8'hE0;
  localparam logic [7:0] B_F0 = 8'hF0;
  localparam logic [7:0] B_E1 = 8'hE1;
  localparam logic [7:0] B_AA = 8'hAA;
  localparam logic [7:0] B_FA = 8'hFA;
  localparam logic [7:0] B_EE = 8'hEE;
  localparam logic [7:0] B_FE = 8'hFE;
  localparam logic [7:0] B_FF = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_e;

  localparam int unsigned KEY_IDX_W = 3;
  localparam int unsigned KEY_NUM   = 8;

  typedef struct packed {
    logic       ext;
    logic [7:0] code;
  } key_id_t;

  localparam key_id_t KEY_UP     = '{ext: 1'b1, code: 8'h75};
  localparam key_id_t KEY_DOWN   = '{ext: 1'b1, code: 8'h72};
  localparam key_id_t KEY_LEFT   = '{ext: 1'b1, code: 8'h6B};
  localparam key_id_t KEY_RIGHT  = '{ext: 1'b1, code: 8'h74};
  localparam key_id_t KEY_FIRE   = '{ext: 1'b0, code: 8'h14};
  localparam key_id_t KEY_USE    = '{ext: 1'b0, code: 8'h29};
  localparam key_id_t KEY_STRAFE = '{ext: 1'b0, code: 8'h11};
  localparam key_id_t KEY_RUN    = '{ext: 1'b0, code: 8'h12};

  localparam logic [KEY_IDX_W-1:0] IDX_UP     = 3'd0;
  localparam logic [KEY_IDX_W-1:0] IDX_DOWN   = 3'd1;
  localparam logic [KEY_IDX_W-1:0] IDX_LEFT   = 3'd2;
  localparam logic [KEY_IDX_W-1:0] IDX_RIGHT  = 3'd3;
  localparam logic [KEY_IDX_W-1:0] IDX_FIRE   = 3'd4;
  localparam logic [KEY_IDX_W-1:0] IDX_USE    = 3'd5;
  localparam logic [KEY_IDX_W-1:0] IDX_STRAFE = 3'd6;
  localparam logic [KEY_IDX_W-1:0] IDX_RUN    = 3'd7;

  // Keyboard status/reply bytes that never start or complete a key event.
  function automatic logic is_ignored(input logic [7:0] b);
    return (b == B_00) || (b == B_AA) || (b == B_E1) || (b == B_EE) ||
           (b == B_FA) || (b == B_FE) || (b == B_FF);
  endfunction

endpackage

// File: rtl/ps2_keymap.sv
// Combinational {ext, code} -> game-key bit index lookup.
module ps2_keymap
  import ps2_kbd_pkg::*;
(
  input  logic                 ext,
  input  logic [7:0]           code,
  output logic                 hit_c,
  output logic [KEY_IDX_W-1:0] idx_c
);

  key_id_t key;

  always_comb begin
    key   = '{ext: ext, code: code};
    hit_c = 1'b1;
    idx_c = '0;
    if      (key == KEY_UP)     idx_c = IDX_UP;
    else if (key == KEY_DOWN)   idx_c = IDX_DOWN;
    else if (key == KEY_LEFT)   idx_c = IDX_LEFT;
    else if (key == KEY_RIGHT)  idx_c = IDX_RIGHT;
    else if (key == KEY_FIRE)   idx_c = IDX_FIRE;
    else if (key == KEY_USE)    idx_c = IDX_USE;
    else if (key == KEY_STRAFE) idx_c = IDX_STRAFE;
    else if (key == KEY_RUN)    idx_c = IDX_RUN;
    else                        hit_c = 1'b0;
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 scan_ready/read handshake, E0/F0 prefix decode, key events and held-key vector.
// Optional TYPEMATIC_FILTER_EN drops auto-repeat makes of already-held mapped keys.
module ps2_key_tracker
  import ps2_kbd_pkg::*;
#(
  parameter int unsigned PREFIX_TIMEOUT = 2_500_000
) (
  input  logic        clock50,
  input  logic        reset,
  input  logic        scan_ready,
  input  logic [7:0]  scan_code,
  output logic        read,
  output logic        event_valid,
  output logic [7:0]  event_code,
  output logic        event_ext,
  output logic        event_break,
  output logic [7:0]  key_state,
  output logic        prefix_err
);

  localparam int unsigned CNT_W = $clog2(PREFIX_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PREFIX_TIMEOUT - 1);

  state_e state_q, state_d;

  logic             armed_q, armed_d;
  logic             read_q, read_d;
  logic [7:0]       byte_q, byte_d;
  logic             byte_vld_q, byte_vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ev_valid_q, ev_valid_d;
  logic [7:0]       ev_code_q, ev_code_d;
  logic             ev_ext_q, ev_ext_d;
  logic             ev_brk_q, ev_brk_d;
  logic [KEY_NUM-1:0] key_state_q, key_state_d;
  logic             prefix_err_q, prefix_err_d;

  logic                 cap_c;
  logic                 timeout_c;
  logic                 ev_fire_c;
  logic                 ev_ext_c;
  logic                 ev_brk_c;
  logic                 emit_c;
  logic                 map_hit_c;
  logic [KEY_IDX_W-1:0] map_idx_c;

  // Handshake: one capture per scan_ready high period.
  always_comb begin
    cap_c      = armed_q & scan_ready;
    armed_d    = armed_q;
    if (cap_c)                        armed_d = 1'b0;
    else if (!armed_q && !scan_ready) armed_d = 1'b1;
    read_d     = cap_c;
    byte_vld_d = cap_c;
    byte_d     = cap_c ? scan_code : byte_q;
  end

  // Prefix timeout; a byte in flight always beats the timeout.
  always_comb begin
    cnt_d = cnt_q;
    if (cap_c || state_q == ST_IDLE) cnt_d = '0;
    else if (cnt_q != '1)            cnt_d = cnt_q + CNT_W'(1);
    timeout_c = (state_q != ST_IDLE) && (cnt_q == CNT_LAST) && !cap_c && !byte_vld_q;
  end

  always_ff @(posedge clock50 or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (byte_vld_q) begin
      unique case (state_q)
        ST_IDLE: begin
          if (byte_q == B_E0)      state_d = ST_EXT;
          else if (byte_q == B_F0) state_d = ST_BRK;
        end
        ST_EXT: begin
          if (byte_q == B_F0)      state_d = ST_EXT_BRK;
          else if (byte_q != B_E0) state_d = ST_IDLE;
        end
        ST_BRK:     state_d = ST_IDLE;
        ST_EXT_BRK: state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end else if (timeout_c) begin
      state_d = ST_IDLE;
    end
  end

  // Event decode outputs.
  always_comb begin
    ev_fire_c = 1'b0;
    ev_ext_c  = 1'b0;
    ev_brk_c  = 1'b0;
    if (byte_vld_q) begin
      unique case (state_q)
        ST_IDLE: ev_fire_c = (byte_q != B_E0) && (byte_q != B_F0) && !is_ignored(byte_q);
        ST_EXT: begin
          ev_fire_c = (byte_q != B_E0) && (byte_q != B_F0);
          ev_ext_c  = 1'b1;
        end
        ST_BRK: begin
          ev_fire_c = (byte_q != B_E0) && (byte_q != B_F0);
          ev_brk_c  = 1'b1;
        end
        ST_EXT_BRK: begin
          ev_fire_c = (byte_q != B_E0) && (byte_q != B_F0);
          ev_ext_c  = 1'b1;
          ev_brk_c  = 1'b1;
        end
        default: ev_fire_c = 1'b0;
      endcase
    end
  end

  ps2_keymap u_keymap (
    .ext   (ev_ext_c),
    .code  (byte_q),
    .hit_c (map_hit_c),
    .idx_c (map_idx_c)
  );

`ifdef TYPEMATIC_FILTER_EN
  logic repeat_c;
  always_comb begin
    repeat_c = ev_fire_c && !ev_brk_c && map_hit_c && key_state_q[map_idx_c];
    emit_c   = ev_fire_c && !repeat_c;
  end
`else
  always_comb emit_c = ev_fire_c;
`endif

  // Registered event payload and held-key vector.
  always_comb begin
    ev_valid_d   = emit_c;
    ev_code_d    = ev_code_q;
    ev_ext_d     = ev_ext_q;
    ev_brk_d     = ev_brk_q;
    key_state_d  = key_state_q;
    prefix_err_d = timeout_c;
    if (emit_c) begin
      ev_code_d = byte_q;
      ev_ext_d  = ev_ext_c;
      ev_brk_d  = ev_brk_c;
      if (map_hit_c) key_state_d[map_idx_c] = !ev_brk_c;
    end
  end

  always_ff @(posedge clock50 or posedge reset) begin
    if (reset) begin
      armed_q      <= 1'b1;
      read_q       <= 1'b0;
      byte_q       <= '0;
      byte_vld_q   <= 1'b0;
      cnt_q        <= '0;
      ev_valid_q   <= 1'b0;
      ev_code_q    <= '0;
      ev_ext_q     <= 1'b0;
      ev_brk_q     <= 1'b0;
      key_state_q  <= '0;
      prefix_err_q <= 1'b0;
    end else begin
      armed_q      <= armed_d;
      read_q       <= read_d;
      byte_q       <= byte_d;
      byte_vld_q   <= byte_vld_d;
      cnt_q        <= cnt_d;
      ev_valid_q   <= ev_valid_d;
      ev_code_q    <= ev_code_d;
      ev_ext_q     <= ev_ext_d;
      ev_brk_q     <= ev_brk_d;
      key_state_q  <= key_state_d;
      prefix_err_q <= prefix_err_d;
    end
  end

  assign read        = read_q;
  assign event_valid = ev_valid_q;
  assign event_code  = ev_code_q;
  assign event_ext   = ev_ext_q;
  assign event_break = ev_brk_q;
  assign key_state   = key_state_q;
  assign prefix_err  = prefix_err_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker with a shortened prefix timeout.
module tb_ps2_key_tracker;

  localparam int unsigned TO = 100;
`ifdef TYPEMATIC_FILTER_EN
  localparam int EXP_REP = 1;
`else
  localparam int EXP_REP = 3;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       scan_ready;
  logic [7:0] scan_code;
  logic       read;
  logic       event_valid;
  logic [7:0] event_code;
  logic       event_ext;
  logic       event_break;
  logic [7:0] key_state;
  logic       prefix_err;

  int n_cmp = 0;
  int n_mis = 0;
  int ev_cnt = 0;
  int rd_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  ps2_key_tracker #(.PREFIX_TIMEOUT(TO)) dut (
    .clock50     (clk),
    .reset       (reset),
    .scan_ready  (scan_ready),
    .scan_code   (scan_code),
    .read        (read),
    .event_valid (event_valid),
    .event_code  (event_code),
    .event_ext   (event_ext),
    .event_break (event_break),
    .key_state   (key_state),
    .prefix_err  (prefix_err)
  );

  always @(negedge clk) begin
    if (event_valid === 1'b1) ev_cnt  <= ev_cnt + 1;
    if (read === 1'b1)        rd_cnt  <= rd_cnt + 1;
    if (prefix_err === 1'b1)  err_cnt <= err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int hold);
    @(negedge clk);
    scan_ready = 1'b1;
    scan_code  = b;
    repeat (hold) @(negedge clk);
    scan_ready = 1'b0;
    scan_code  = 8'h00;
    repeat (3) @(negedge clk);
    #2;
  endtask

  task automatic check_event(input string tag, input int e0, input int n,
                             input logic [7:0] code, input logic ext, input logic brk);
    check({tag, "_cnt"}, 32'(ev_cnt - e0), 32'(n));
    check({tag, "_code"}, 32'(event_code), 32'(code));
    check({tag, "_ext"}, 32'(event_ext), 32'(ext));
    check({tag, "_brk"}, 32'(event_break), 32'(brk));
  endtask

  initial begin
    int e0, r0, x0, wait_n;
    reset      = 1'b1;
    scan_ready = 1'b0;
    scan_code  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_read", 32'(read), 32'h0);
    check("rst_valid", 32'(event_valid), 32'h0);
    check("rst_code", 32'(event_code), 32'h0);
    check("rst_ext", 32'(event_ext), 32'h0);
    check("rst_brk", 32'(event_break), 32'h0);
    check("rst_keys", 32'(key_state), 32'h0);
    check("rst_err", 32'(prefix_err), 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: long scan_ready high, single read and single event
    e0 = ev_cnt; r0 = rd_cnt;
    send(8'h1D, 20);
    check("t1_reads", 32'(rd_cnt - r0), 32'd1);
    check_event("t1", e0, 1, 8'h1D, 1'b0, 1'b0);

    // 2: extended make then extended break of up arrow
    e0 = ev_cnt;
    send(8'hE0, 1); send(8'h75, 1);
    check_event("t2m", e0, 1, 8'h75, 1'b1, 1'b0);
    check("t2m_keys", 32'(key_state), 32'h01);
    e0 = ev_cnt;
    send(8'hE0, 1); send(8'hF0, 1); send(8'h75, 1);
    check_event("t2b", e0, 1, 8'h75, 1'b1, 1'b1);
    check("t2b_keys", 32'(key_state), 32'h00);

    // 3: left ctrl maps, right ctrl (E0 14) does not
    e0 = ev_cnt;
    send(8'h14, 1);
    check_event("t3a", e0, 1, 8'h14, 1'b0, 1'b0);
    check("t3a_keys", 32'(key_state), 32'h10);
    e0 = ev_cnt;
    send(8'hE0, 1); send(8'h14, 1);
    check_event("t3b", e0, 1, 8'h14, 1'b1, 1'b0);
    check("t3b_keys", 32'(key_state), 32'h10);

    // ignored byte and malformed break produce nothing
    e0 = ev_cnt;
    send(8'hAA, 1);
    send(8'hF0, 1); send(8'hE0, 1);
    check("ign_cnt", 32'(ev_cnt - e0), 32'd0);
    e0 = ev_cnt;
    send(8'h1C, 1);
    check_event("after_mal", e0, 1, 8'h1C, 1'b0, 1'b0);

    // 4: dangling F0 times out, following byte is a plain make
    e0 = ev_cnt; x0 = err_cnt;
    send(8'hF0, 1);
    wait_n = 0;
    for (int i = 0; i < 4 * TO && err_cnt == x0; i++) begin
      @(negedge clk);
      wait_n++;
    end
    repeat (3) @(negedge clk);
    #2;
    check("t4_err_cnt", 32'(err_cnt - x0), 32'd1);
    check("t4_window", 32'((wait_n >= 90) && (wait_n <= 110)), 32'd1);
    check("t4_no_event", 32'(ev_cnt - e0), 32'd0);
    send(8'h29, 1);
    check_event("t4m", e0, 1, 8'h29, 1'b0, 1'b0);
    check("t4_keys", 32'(key_state), 32'h30);

    // 5: typematic repeats of a mapped key
    send(8'hF0, 1); send(8'h29, 1);
    check("t5_clr", 32'(key_state), 32'h10);
    e0 = ev_cnt;
    send(8'h29, 1); send(8'h29, 1); send(8'h29, 1);
    check("t5_cnt", 32'(ev_cnt - e0), 32'(EXP_REP));
    check("t5_keys", 32'(key_state), 32'h30);

    // 6: reset with a held key and pending state
    send(8'hE0, 1); send(8'h72, 1);
    check("t6_keys", 32'(key_state), 32'h32);
    send(8'hE0, 1);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("t6_rst_keys", 32'(key_state), 32'h0);
    check("t6_rst_code", 32'(event_code), 32'h0);
    check("t6_rst_ext", 32'(event_ext), 32'h0);
    check("t6_rst_valid", 32'(event_valid), 32'h0);
    reset = 1'b0;
    e0 = ev_cnt;
    send(8'h72, 1);
    check_event("t6m", e0, 1, 8'h72, 1'b0, 1'b0);
    check("t6_keys_after", 32'(key_state), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
